// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight destination tracker giving ID stall/bubble/forward selects; define HAZARD_FWD_EN to enable forwarding
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int STAGES = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W = 16,
  localparam int SEL_W = $clog2(STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ext_hold,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_is_load,
  output logic                  stall_if,
  output logic                  bubble_ex,
  output logic [SEL_W-1:0]      fwd_rs_sel,
  output logic [SEL_W-1:0]      fwd_rt_sel,
  output logic [CNT_W-1:0]      stall_cnt
);
  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_load;
  } slot_t;
  slot_t [STAGES-1:0] slot_q, slot_d;
  slot_t issue;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0][REG_ADDR_W-1:0] src;
  logic [1:0] use_src, src_haz;
  logic [1:0][SEL_W-1:0] src_sel;
  logic hazard;
  assign src = {id_rt, id_rs};
  assign use_src = {id_use_rt, id_use_rs};
  // descending scan so the youngest (lowest) matching slot wins
  always_comb begin
    src_haz = '0;
    src_sel = '0;
    for (int s = 0; s < 2; s++)
      for (int k = STAGES - 1; k >= 0; k--)
        if (slot_q[k].valid && slot_q[k].wr_en && slot_q[k].rd != '0 &&
            slot_q[k].rd == src[s] && use_src[s]) begin
`ifdef HAZARD_FWD_EN
          src_haz[s] = slot_q[k].is_load && k < LOAD_LAT;
          src_sel[s] = SEL_W'(k + 1);
`else
          src_haz[s] = (slot_q[k].is_load && k < LOAD_LAT) || k < STAGES - 1;
`endif
        end
  end
  assign hazard = id_valid && !flush && |src_haz;
  assign stall_if = hazard && !ext_hold;
  assign bubble_ex = (hazard || flush) && !ext_hold;
  assign fwd_rs_sel = (hazard || ext_hold) ? '0 : src_sel[0];
  assign fwd_rt_sel = (hazard || ext_hold) ? '0 : src_sel[1];
  assign stall_cnt = cnt_q;
  assign issue = slot_t'{valid: id_valid && !flush && !hazard, wr_en: id_wr_en, rd: id_rd, is_load: id_is_load};
  assign slot_d = {slot_q[STAGES-2:0], issue};
  assign cnt_d = (stall_if && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q <= '0;
      cnt_q <= '0;
    end else if (!ext_hold) begin
      slot_q <= slot_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors with a queue-based scoreboard and a negedge monitor
module tb_hazard_scoreboard;
  logic clk = 1'b0, reset = 1'b0, ext_hold = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic id_use_rs = 1'b0, id_use_rt = 1'b0, id_wr_en = 1'b0, id_is_load = 1'b0;
  logic stall_if, bubble_ex;
  logic [1:0] fwd_rs_sel, fwd_rt_sel, stall_cnt;
  int compared = 0, mismatched = 0;
  logic [7:0] exp_q[$];
  string nm_q[$];

  hazard_scoreboard #(.REG_ADDR_W(5), .STAGES(3), .LOAD_LAT(1), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .ext_hold(ext_hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wr_en(id_wr_en), .id_rd(id_rd), .id_is_load(id_is_load),
    .stall_if(stall_if), .bubble_ex(bubble_ex), .fwd_rs_sel(fwd_rs_sel),
    .fwd_rt_sel(fwd_rt_sel), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  function automatic logic [7:0] ex(input bit st, input bit bb, input int rs, input int rt, input int cnt);
    return {st, bb, 2'(rs), 2'(rt), 2'(cnt)};
  endfunction

  task automatic cyc(input bit rv, input bit v, input bit fl, input bit hd,
                     input int rs, input int rt, input bit urs, input bit urt,
                     input bit wen, input int rd, input bit ld, input logic [7:0] e, input string nm);
    @(posedge clk);
    #1;
    id_valid = v; flush = fl; ext_hold = hd;
    id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
    id_wr_en = wen; id_rd = 5'(rd); id_is_load = ld;
    reset = rv;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [7:0] e, g;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      g = {stall_if, bubble_ex, fwd_rs_sel, fwd_rt_sel, stall_cnt};
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL %s: got stall=%b bubble=%b rs_sel=%0d rt_sel=%0d cnt=%0d, want stall=%b bubble=%b rs_sel=%0d rt_sel=%0d cnt=%0d",
                 n, g[7], g[6], g[5:4], g[3:2], g[1:0], e[7], e[6], e[5:4], e[3:2], e[1:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
`ifdef HAZARD_FWD_EN
    cyc(1,0,0,0, 0,0,0,0, 0,0,0, ex(0,0,0,0,0), "reset");
    cyc(1,1,0,0, 0,0,0,0, 1,3,0, ex(0,0,0,0,0), "wr_r3");
    cyc(1,1,0,0, 3,0,1,0, 0,0,0, ex(0,0,1,0,0), "fwd_slot0");
    cyc(1,1,0,0, 3,0,1,0, 0,0,0, ex(0,0,2,0,0), "fwd_slot1");
    cyc(1,1,0,0, 3,0,1,0, 0,0,0, ex(0,0,3,0,0), "fwd_slot2");
    cyc(1,1,0,0, 0,0,0,0, 1,5,1, ex(0,0,0,0,0), "lw_r5");
    cyc(1,1,0,0, 0,5,0,1, 0,0,0, ex(1,1,0,0,0), "load_use");
    cyc(1,1,0,0, 0,5,0,1, 0,0,0, ex(0,0,0,2,1), "load_fwd");
    cyc(1,1,0,0, 0,0,0,0, 1,7,0, ex(0,0,0,0,1), "wr_r7a");
    cyc(1,1,0,0, 0,0,0,0, 1,7,0, ex(0,0,0,0,1), "wr_r7b");
    cyc(1,1,0,0, 7,0,1,0, 0,0,0, ex(0,0,1,0,1), "youngest");
    cyc(1,1,0,0, 0,0,0,0, 1,0,0, ex(0,0,0,0,1), "wr_r0");
    cyc(1,1,0,0, 0,0,1,1, 0,0,0, ex(0,0,0,0,1), "r0_nofwd");
    cyc(1,1,0,0, 0,0,0,0, 1,5,1, ex(0,0,0,0,1), "lw_r5b");
    cyc(1,1,1,0, 5,0,1,0, 1,8,0, ex(0,1,0,0,1), "flush");
    cyc(1,1,0,0, 8,0,1,0, 0,0,0, ex(0,0,0,0,1), "flush_bubble");
    cyc(1,1,0,0, 0,0,0,0, 1,4,1, ex(0,0,0,0,1), "lw_r4");
    cyc(1,1,0,0, 4,0,1,0, 0,0,0, ex(1,1,0,0,1), "pre_reset_stall");
    cyc(0,1,0,0, 4,0,1,0, 0,0,0, ex(0,0,0,0,0), "reset_mid_stall");
    cyc(1,0,0,0, 0,0,0,0, 0,0,0, ex(0,0,0,0,0), "post_reset");
    cyc(1,1,0,0, 4,0,1,0, 0,0,0, ex(0,0,0,0,0), "reset_cleared");
`else
    cyc(1,0,0,0, 0,0,0,0, 0,0,0, ex(0,0,0,0,0), "reset");
    cyc(1,1,0,0, 0,0,0,0, 1,4,0, ex(0,0,0,0,0), "wr_r4");
    cyc(1,1,0,0, 4,0,1,0, 0,0,0, ex(1,1,0,0,0), "alu_stall1");
    cyc(1,1,0,0, 4,0,1,0, 0,0,0, ex(1,1,0,0,1), "alu_stall2");
    cyc(1,1,0,0, 4,0,1,0, 0,0,0, ex(0,0,0,0,2), "alu_release");
    cyc(1,1,0,0, 0,0,0,0, 1,6,0, ex(0,0,0,0,2), "wr_r6");
    cyc(1,1,0,0, 0,6,0,1, 0,0,0, ex(1,1,0,0,2), "stall_r6");
    cyc(1,1,0,1, 0,6,0,1, 0,0,0, ex(0,0,0,0,3), "hold1");
    cyc(1,1,0,1, 0,6,0,1, 0,0,0, ex(0,0,0,0,3), "hold2");
    cyc(1,1,0,0, 0,6,0,1, 0,0,0, ex(1,1,0,0,3), "stall_after_hold");
    cyc(1,1,0,0, 0,6,0,1, 0,0,0, ex(0,0,0,0,3), "sat_release");
    cyc(1,1,0,0, 0,0,0,0, 1,0,0, ex(0,0,0,0,3), "wr_r0");
    cyc(1,1,0,0, 0,0,1,1, 0,0,0, ex(0,0,0,0,3), "rd_r0");
    cyc(1,1,0,0, 0,0,0,0, 1,9,0, ex(0,0,0,0,3), "wr_r9");
    cyc(1,0,0,0, 9,0,1,0, 0,0,0, ex(0,0,0,0,3), "invalid_id");
    cyc(1,1,0,0, 9,9,0,0, 0,0,0, ex(0,0,0,0,3), "no_use");
    cyc(1,1,0,0, 0,0,0,0, 1,5,1, ex(0,0,0,0,3), "lw_r5");
    cyc(1,1,1,0, 5,0,1,0, 1,8,0, ex(0,1,0,0,3), "flush");
    cyc(1,1,0,0, 8,0,1,0, 0,0,0, ex(0,0,0,0,3), "flush_bubble");
    cyc(1,1,0,0, 0,0,0,0, 1,4,0, ex(0,0,0,0,3), "wr_r4b");
    cyc(1,1,0,0, 4,0,1,0, 0,0,0, ex(1,1,0,0,3), "pre_reset_stall");
    cyc(0,1,0,0, 4,0,1,0, 0,0,0, ex(0,0,0,0,0), "reset_mid_stall");
    cyc(1,0,0,0, 0,0,0,0, 0,0,0, ex(0,0,0,0,0), "post_reset");
    cyc(1,1,0,0, 4,0,1,0, 0,0,0, ex(0,0,0,0,0), "reset_cleared");
`endif
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard scoreboard for the five-stage MIPS pipeline. It replaces the hand-chained per-stage stall flags between IF, ID and EX with one tracking block. The block sits beside the ID stage and records the destination of every instruction in flight from EX to WB. For each decoding instruction it produces the IF/ID stall, the ID/EX bubble and the operand forwarding selects, and it keeps a saturating stall-cycle counter.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width.
- STAGES, 3, in-flight slots tracked. Slot 0 = EX, slot 1 = DM, slot STAGES-1 = WB.
- LOAD_LAT, 1, lowest slot index at which a load result is forwardable.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- ext_hold  in  1  memory-side freeze; scoreboard and counter hold.
- flush  in  1  branch taken; kill the instruction in ID.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_ADDR_W  source register addresses.
- id_use_rs, id_use_rt  in  1  the source is actually read.
- id_wr_en  in  1  instruction writes a register.
- id_rd  in  REG_ADDR_W  destination after reg_dst mux.
- id_is_load  in  1  instruction is a load (mem_to_reg).
- stall_if  out  1  hold PC and IF/ID.
- bubble_ex  out  1  load NOP controls into ID/EX.
- fwd_rs_sel, fwd_rt_sel  out  $clog2(STAGES+1)  0 = register file, k+1 = slot k.
- stall_cnt  out  CNT_W  cycles with stall_if=1 since reset, saturating.

## Operation
- Each slot holds {valid, wr_en, rd, is_load}.
- Match rule: slot k matches a source when valid && wr_en && rd!=0 && rd==src && use_src. The lowest matching k (youngest) wins.
- Hazard rule for one source: the nearest match is a load with k < LOAD_LAT, or forwarding is compiled out (see Configuration).
- hazard = id_valid && !flush && (rs hazard || rt hazard).
- stall_if = hazard && !ext_hold.
- bubble_ex = (hazard || flush) && !ext_hold.
- fwd_*_sel = k+1 for the nearest non-hazard match; otherwise 0. When hazard=1, both selects are 0.
- Slot update on posedge, ext_hold=0:
  - Slots shift (slot k takes slot k-1); slot STAGES-1 retires.
  - Slot 0 loads the ID instruction if id_valid && !flush && !hazard; otherwise it loads a bubble (valid=0).
- ext_hold=1: all slots and stall_cnt hold; all outputs except stall_cnt are forced to 0.
- Priority: reset > ext_hold > flush > hazard.
- stall_cnt increments when stall_if=1 and saturates at 2^CNT_W-1; it does not wrap.
- Register 0 is never a hazard and is never forwarded.

## Timing
- stall_if, bubble_ex and fwd_*_sel are combinational from the current slots and the ID inputs in the same cycle.
- Slots and stall_cnt are registered.
- Load-use with LOAD_LAT=1: exactly 1 stall cycle, then forwarding from slot 1.
- Reset asserted, including mid-stall: all slots invalid, stall_cnt=0 immediately, which drives stall_if=0, bubble_ex=0 and fwd sels=0 asynchronously.
- First posedge after reset release may issue.
- The register file writes in WB before ID reads in the same cycle, so a match in slot STAGES-1 never stalls.

## Configuration
- HAZARD_FWD_EN defined: forwarding as above; only load-use stalls.
- HAZARD_FWD_EN undefined:
  - fwd_*_sel tied to 0.
  - Any match in slots 0..STAGES-2 is a hazard.
  - An ALU-use dependence stalls STAGES-1 cycles.

## Test plan
- FWD_EN: slot0 = add r3 (wr_en, rd=3); ID add reads rs=3 -> stall_if=0, fwd_rs_sel=1; next cycle a reader of r3 gets fwd_rs_sel=2.
- FWD_EN: lw r5 then add rt=5 -> stall_if=1 and bubble_ex=1 for exactly one cycle, then fwd_rt_sel=2; stall_cnt=1.
- Writer with rd=0 followed by a reader of r0 -> no stall, fwd sel=0. Two writers of r7 in slots 0 and 1 -> fwd sel=1 (youngest).
- lw r5 in slot0, ID reads r5, flush=1 -> stall_if=0, bubble_ex=1, and slot 0 holds a bubble next cycle.
- Without the macro: slot0 = add r4, ID reads r4 -> stall_if=1 for 2 cycles, released when the writer reaches slot 2; stall_cnt=2. ext_hold=1 mid-stall -> slots and stall_cnt frozen, stall_if=0.
- Reset pulled low during an active stall -> outputs 0 and stall_cnt=0 without a clock edge. stall_cnt with CNT_W=2 saturates at 3.
